// File: rtl/pipelined_lookahead_adder.sv
// pipelined_lookahead_adder
//
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow
// control. The operands are cut into STAGES equal slices. Stage k sums slice k
// using GROUP-bit lookahead groups. A second-level lookahead unit computes
// the carry-in of every group in parallel from the group G/P terms. The carry
// out of each slice is registered and handed to the next stage.
//
// Ports
//   Clk        clock, all state on the rising edge
//   Reset      synchronous, active-high reset
//   in_valid   operand transaction offered
//   in_ready   block accepts a transaction this cycle
//   A, B       operands (WIDTH bits)
//   Cin        carry-in (add) / borrow-in (sub)
//   Sub        0: add, 1: subtract (A - B - Cin)
//   out_valid  result registers hold a valid result
//   out_ready  downstream consumes the result this cycle
//   S          sum/difference modulo 2^WIDTH
//   CO         raw carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   OV         signed two's-complement overflow
module pipelined_lookahead_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int SW = WIDTH / STAGES;  // bits per slice
  localparam int NG = SW / GROUP;      // lookahead groups per slice

  if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_params
    $error("pipelined_lookahead_adder: WIDTH must be a multiple of GROUP*STAGES");
  end

  // One pipeline stage. a/b carry the not-yet-summed operand slices (b is
  // already inverted for subtraction), s the finished sum slices, c the carry
  // into the next slice and cm the carry into the slice's top bit (only the
  // last stage's cm is meaningful: it feeds OV).
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } stage_t;

  typedef struct packed {
    logic [SW-1:0] s;
    logic          cout;
    logic          cmsb;
  } slice_t;

  // Two-level lookahead sum of one slice. Every carry is written as an
  // explicit sum-of-products of G/P terms and the slice carry-in, so neither
  // groups nor bits inside a group ripple into each other.
  function automatic slice_t slice_add(input logic [SW-1:0] a,
                                       input logic [SW-1:0] b,
                                       input logic          cin);
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp, gc;
    logic          cj, term;
    slice_t        res;
    g   = a & b;
    p   = a ^ b;
    gc  = '0;
    res = '0;
    // First level: group generate / propagate.
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
    // Second level: carry into each group (j == NG is the slice carry out).
    for (int j = 0; j <= NG; j++) begin
      cj = cin;
      for (int n = 0; n < j; n++) cj = cj & gp[n];
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int n = m + 1; n < j; n++) term = term & gp[n];
        cj = cj | term;
      end
      if (j < NG) gc[j] = cj;
      else        res.cout = cj;
    end
    // Bit carries inside each group, from that group's carry-in only.
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        cj = gc[j];
        for (int n = 0; n < i; n++) cj = cj & p[j*GROUP+n];
        for (int m = 0; m < i; m++) begin
          term = g[j*GROUP+m];
          for (int n = m + 1; n < i; n++) term = term & p[j*GROUP+n];
          cj = cj | term;
        end
        c[j*GROUP+i] = cj;
      end
    end
    res.s    = p ^ c;
    res.cmsb = c[SW-1];
    return res;
  endfunction

  stage_t r [STAGES];  // stage registers; r[STAGES-1] drives the outputs
  stage_t d [STAGES];  // next value of each stage register
  logic   adv;

  // A single global enable: everything moves, or everything holds.
  assign adv       = !r[STAGES-1].valid || out_ready;
  assign in_ready  = adv && !Reset;
  assign out_valid = r[STAGES-1].valid;
  assign S         = r[STAGES-1].s;
  assign CO        = r[STAGES-1].c;
  assign OV        = r[STAGES-1].cm ^ r[STAGES-1].c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src, nxt;
    slice_t res;

    if (k == 0) begin : g_first
      always_comb begin
        // NOTE: assign a default to every field first so no path leaves a
        // bit unassigned; a combinational block that misses one infers a latch.
        src       = '0;
        src.valid = in_valid && in_ready;
        src.a     = A;
        src.b     = Sub ? ~B : B;
        src.c     = Cin ^ Sub;
      end
    end else begin : g_next
      assign src = r[k-1];
    end

    always_comb begin
      res               = slice_add(src.a[k*SW +: SW], src.b[k*SW +: SW], src.c);
      nxt               = src;
      nxt.s[k*SW +: SW] = res.s;
      nxt.c             = res.cout;
      nxt.cm            = res.cmsb;
    end

    assign d[k] = nxt;
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // stage samples its predecessor's pre-edge value, regardless of order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) r[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) r[k] <= d[k];
    end
  end

  // Operand bits of finished slices and the cm bits of inner stages are dead
  // by construction; gather them into one sink.
  logic unused_ok;
  always_comb begin
    unused_ok = 1'b0;
    for (int k = 0; k < STAGES; k++) unused_ok = unused_ok ^ (^r[k]);
  end

endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// Directed testbench for pipelined_lookahead_adder: a 32/4/2 instance with
// full flow-control checks, plus 16/4/1, 16/4/4 and 64/8/2 instances for the
// parameter sweep.
module tb_pipelined_lookahead_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic        m_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [31:0] m_a, m_b, m_s;
  logic        m_cin, m_sub, m_co, m_ov;

  // Sweep instances share one stimulus bus
  logic        sw_valid, sw_cin, sw_sub;
  logic        sw_out_ready = 1'b1;
  logic [63:0] sw_a, sw_b;
  logic        x1_in_ready, x1_out_valid, x1_co, x1_ov;
  logic        x4_in_ready, x4_out_valid, x4_co, x4_ov;
  logic        x8_in_ready, x8_out_valid, x8_co, x8_ov;
  logic [15:0] x1_s, x4_s;
  logic [63:0] x8_s;

  pipelined_lookahead_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .Clk(clk), .Reset(reset), .in_valid(m_valid), .in_ready(m_in_ready),
    .A(m_a), .B(m_b), .Cin(m_cin), .Sub(m_sub), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .S(m_s), .CO(m_co), .OV(m_ov));

  pipelined_lookahead_adder #(.WIDTH(16), .GROUP(4), .STAGES(1)) dut_x1 (
    .Clk(clk), .Reset(reset), .in_valid(sw_valid), .in_ready(x1_in_ready),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .Cin(sw_cin), .Sub(sw_sub),
    .out_valid(x1_out_valid), .out_ready(sw_out_ready), .S(x1_s), .CO(x1_co), .OV(x1_ov));

  pipelined_lookahead_adder #(.WIDTH(16), .GROUP(4), .STAGES(4)) dut_x4 (
    .Clk(clk), .Reset(reset), .in_valid(sw_valid), .in_ready(x4_in_ready),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .Cin(sw_cin), .Sub(sw_sub),
    .out_valid(x4_out_valid), .out_ready(sw_out_ready), .S(x4_s), .CO(x4_co), .OV(x4_ov));

  pipelined_lookahead_adder #(.WIDTH(64), .GROUP(8), .STAGES(2)) dut_x8 (
    .Clk(clk), .Reset(reset), .in_valid(sw_valid), .in_ready(x8_in_ready),
    .A(sw_a), .B(sw_b), .Cin(sw_cin), .Sub(sw_sub),
    .out_valid(x8_out_valid), .out_ready(sw_out_ready), .S(x8_s), .CO(x8_co), .OV(x8_ov));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: {CO, OV, S} of A + Beff + ceff at width w, S zero-extended.
  function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin,
                                        input logic sub);
    logic [64:0] mask, lmask, aa, bb, sum, low;
    logic        c, co, ov;
    mask  = (65'd1 << w) - 65'd1;
    lmask = (65'd1 << (w - 1)) - 65'd1;
    aa    = {1'b0, a} & mask;
    bb    = {1'b0, (sub ? ~b : b)} & mask;
    c     = cin ^ sub;
    sum   = aa + bb + {64'd0, c};
    low   = (aa & lmask) + (bb & lmask) + {64'd0, c};
    co    = sum[w];
    ov    = low[w-1] ^ co;
    return {co, ov, sum[63:0] & mask[63:0]};
  endfunction

  function automatic logic [65:0] m_out();
    return {m_co, m_ov, 32'h0, m_s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance with hand-computed expectations.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic eco, input logic eov);
    m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_valid = 1'b1; m_out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 66'(m_in_ready), 66'd1);
    tick();
    m_valid = 1'b0;
    check({tag, " not yet valid"}, 66'(m_out_valid), 66'd0);
    tick();
    check({tag, " out_valid"}, 66'(m_out_valid), 66'd1);
    check({tag, " result"}, m_out(), {eco, eov, 32'h0, es});
  endtask

  // One transaction on all sweep instances; each must answer after exactly
  // STAGES edges (x1: 1, x8: 2, x4: 4).
  task automatic sweep_vec(input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub);
    logic [65:0] e16, e64;
    e16 = model(16, a, b, cin, sub);
    e64 = model(64, a, b, cin, sub);
    sw_a = a; sw_b = b; sw_cin = cin; sw_sub = sub; sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 0) begin
        check("x1 out_valid", 66'(x1_out_valid), 66'd1);
        check("x1 result", {x1_co, x1_ov, 48'h0, x1_s}, e16);
        check("x8 early", 66'(x8_out_valid), 66'd0);
      end
      if (cyc == 1) begin
        check("x8 out_valid", 66'(x8_out_valid), 66'd1);
        check("x8 result", {x8_co, x8_ov, x8_s}, e64);
      end
      if (cyc == 2) check("x4 early", 66'(x4_out_valid), 66'd0);
      if (cyc == 3) begin
        check("x4 out_valid", 66'(x4_out_valid), 66'd1);
        check("x4 result", {x4_co, x4_ov, 48'h0, x4_s}, e16);
      end
      tick();
    end
  endtask

  logic [65:0] q[$];
  logic [65:0] snap, exp_v;
  logic [31:0] cur_a, cur_b;
  logic        cur_cin, cur_sub, acc, stalled;
  int          sent, got;
  logic [63:0] cv [4];

  initial begin
    reset = 1'b1;
    m_valid = 1'b1; m_out_ready = 1'b1; m_a = 32'h1234_5678; m_b = 32'h1;
    m_cin = 1'b0; m_sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;

    // Reset held two cycles with in_valid high
    tick();
    tick();
    check("reset out_valid", 66'(m_out_valid), 66'd0);
    check("reset result", m_out(), 66'd0);
    check("reset in_ready", 66'(m_in_ready), 66'd0);
    reset = 1'b0;
    m_valid = 1'b0;
    #1;
    check("in_ready after release", 66'(m_in_ready), 66'd1);
    tick();

    // Directed single transactions (cross-slice carries, subtract, overflow)
    single("add ffffffff+1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single("sub 80000000-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single("sub 3-5-1", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    single("add 7fffffff+1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("add 0000ffff+1", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    single("add with cin", 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0);
    tick();
    check("idle after singles", 66'(m_out_valid), 66'd0);

    // Back-pressure: continuous in_valid, out_ready pattern 1,0,0,1,...
    sent = 0; got = 0; stalled = 1'b0; snap = '0;
    cur_a = $urandom; cur_b = $urandom; cur_cin = 1'($urandom); cur_sub = 1'($urandom);
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      m_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      m_valid = (sent < 8);
      m_a = cur_a; m_b = cur_b; m_cin = cur_cin; m_sub = cur_sub;
      #1;
      if (stalled) begin
        check("stall holds out_valid", 66'(m_out_valid), 66'd1);
        check("stall holds result", m_out(), snap);
      end
      if (m_out_valid && m_out_ready) begin
        if (q.size() == 0) begin
          check("unexpected output", 66'(m_out_valid), 66'd0);
        end else begin
          exp_v = q.pop_front();
          check("stream result", m_out(), exp_v);
        end
        got++;
      end
      stalled = m_out_valid && !m_out_ready;
      if (stalled) begin
        snap = m_out();
        check("in_ready low in stall", 66'(m_in_ready), 66'd0);
      end
      acc = m_valid && m_in_ready;
      tick();
      if (acc) begin
        q.push_back(model(32, {32'h0, cur_a}, {32'h0, cur_b}, cur_cin, cur_sub));
        sent++;
        cur_a = $urandom; cur_b = $urandom; cur_cin = 1'($urandom); cur_sub = 1'($urandom);
      end
    end
    m_valid = 1'b0;
    m_out_ready = 1'b1;
    check("stream received count", 66'(got), 66'd8);
    check("stream queue drained", 66'(q.size()), 66'd0);
    tick();
    tick();
    check("no duplicate after stream", 66'(m_out_valid), 66'd0);

    // Reset mid-flight on the main instance
    m_a = 32'hDEAD_BEEF; m_b = 32'h1111_1111; m_cin = 1'b0; m_sub = 1'b0; m_valid = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("in_ready during reset", 66'(m_in_ready), 66'd0);
    tick();
    reset = 1'b0;
    m_valid = 1'b0;
    check("flushed at reset", 66'(m_out_valid), 66'd0);
    tick();
    check("flushed +1", 66'(m_out_valid), 66'd0);
    tick();
    check("flushed +2", 66'(m_out_valid), 66'd0);
    single("after flush", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
    tick();

    // Reset mid-flight on the 4-stage instance with two transactions inside
    sw_a = 64'h1; sw_b = 64'h2; sw_valid = 1'b1;
    tick();
    sw_a = 64'h3; sw_b = 64'h4;
    tick();
    sw_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("x4 flushed", 66'(x4_out_valid), 66'd0);
      check("x8 flushed", 66'(x8_out_valid), 66'd0);
      tick();
    end

    // Parameter sweep: corner operands in both modes, then random
    cv[0] = 64'h0;
    cv[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    cv[2] = 64'h5555_5555_5555_5555;
    cv[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int s = 0; s < 2; s++)
          sweep_vec(cv[i], cv[j], 1'((i + j) % 2), 1'(s));
    for (int n = 0; n < 8; n++)
      sweep_vec({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
